// File: rtl/bcd_bin.sv
// Sequential packed-BCD to binary converter (reverse double-dabble), one shift step per clock.
// Converts keyed-in BCD digit values back to binary for counters and comparators.

module bcd_bin_chk #(
    parameter int BCD_W = 8,
    parameter int BIN_W = 8,
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             rst_n,
    input logic             done,
    input logic             err_flag,
    input logic [BCD_W-1:0] bcd_rem,
    input logic [CNT_W-1:0] cnt,
    input logic             busy,
    input logic             dout_vld
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    // A valid word must leave no residue in the BCD half after the last step
    a_bcd_drained: assert property (@(posedge clk) disable iff (!rst_n)
        (done && !err_flag) |-> (bcd_rem == {BCD_W{1'b0}}));

    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        cnt <= CNT_LAST);

    a_vld_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(busy && dout_vld));

endmodule

module bcd_bin #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  din_vld,
    output logic                  busy,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err_out,
    output logic                  dout_vld
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SH_W  = BCD_W + BIN_W;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // One reverse double-dabble step: shift right, then pull every BCD nibble >= 8 down by 3
    function automatic logic [SH_W-1:0] dabble_step(input logic [SH_W-1:0] sh);
        logic [SH_W-1:0] t;
        logic [3:0]      nib;
        t = sh >> 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            nib = t[BIN_W + 4*d +: 4];
            if (nib >= 4'd8) begin
                t[BIN_W + 4*d +: 4] = nib - 4'd3;
            end else begin
                t[BIN_W + 4*d +: 4] = nib;
            end
        end
        return t;
    endfunction

    function automatic logic has_bad_digit(input logic [BCD_W-1:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    state_t             state_r, state_s;
    logic [SH_W-1:0]    sh_r, sh_s, step_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               err_flag_r, err_flag_s;
    logic               busy_r;
    logic [BIN_W-1:0]   bin_out_r, bin_out_s;
    logic               err_out_r, err_out_s;
    logic               dout_vld_r, dout_vld_s;
    logic               done_s;

    // Next-state and datapath update for the IDLE/CONV sequencer
    always_comb begin
        state_s    = state_r;
        sh_s       = sh_r;
        cnt_s      = cnt_r;
        err_flag_s = err_flag_r;
        bin_out_s  = bin_out_r;
        err_out_s  = err_out_r;
        dout_vld_s = 1'b0;
        step_s     = dabble_step(sh_r);
        done_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (din_vld) begin
                    state_s    = CONV;
                    sh_s       = {bcd_in, {BIN_W{1'b0}}};
                    cnt_s      = {CNT_W{1'b0}};
                    err_flag_s = has_bad_digit(bcd_in);
                end else begin
                    state_s = IDLE;
                end
            end
            CONV: begin
                sh_s = step_s;
                if (cnt_r == CNT_LAST) begin
                    // Invalid words still run full length so latency never depends on data
                    state_s    = IDLE;
                    cnt_s      = {CNT_W{1'b0}};
                    bin_out_s  = err_flag_r ? {BIN_W{1'b0}} : step_s[BIN_W-1:0];
                    err_out_s  = err_flag_r;
                    dout_vld_s = 1'b1;
                    done_s     = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            sh_r       <= {SH_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            err_flag_r <= 1'b0;
            busy_r     <= 1'b0;
            bin_out_r  <= {BIN_W{1'b0}};
            err_out_r  <= 1'b0;
            dout_vld_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            sh_r       <= sh_s;
            cnt_r      <= cnt_s;
            err_flag_r <= err_flag_s;
            busy_r     <= (state_s == CONV);
            bin_out_r  <= bin_out_s;
            err_out_r  <= err_out_s;
            dout_vld_r <= dout_vld_s;
        end
    end

    assign busy     = busy_r;
    assign bin_out  = bin_out_r;
    assign err_out  = err_out_r;
    assign dout_vld = dout_vld_r;

    bcd_bin_chk #(
        .BCD_W (BCD_W),
        .BIN_W (BIN_W),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .done     (done_s),
        .err_flag (err_flag_r),
        .bcd_rem  (step_s[SH_W-1:BIN_W]),
        .cnt      (cnt_r),
        .busy     (busy_r),
        .dout_vld (dout_vld_r)
    );

endmodule
